// File: rtl/pc_predict_unit.sv
// rtl/pc_predict_unit.sv - fetch PC register with taken-jump and return-address-stack prediction
module pc_predict_unit #(
  parameter int                 ADDR_W    = 64,
  parameter int                 RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              f_valid_i,
  input  logic [3:0]        f_icode_i,
  input  logic [ADDR_W-1:0] f_valC_i,
  input  logic [ADDR_W-1:0] f_valP_i,
  input  logic              r_valid_i,
  input  logic [3:0]        r_icode_i,
  input  logic              r_cnd_i,
  input  logic [ADDR_W-1:0] r_valP_i,
  input  logic [ADDR_W-1:0] r_valM_i,
  input  logic [ADDR_W-1:0] r_pred_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              flush_o,
  output logic              halted_o,
  output logic              ras_ovf_o
);

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_RET_WAIT = 2'd1,
    S_HALT     = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              flush_q, flush_d;
  logic              ovf_q, ovf_d;
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  logic jxx_mispredict;
  logic ret_resolve;
  logic ret_mispredict;
  logic wait_exit;
  logic redirect;
  logic predict_en;
  logic ras_empty;
  logic ras_full;
  logic do_push;
  logic do_pop;

  // Classify the resolve-stage instruction and decide whether this edge predicts.
  // A RET resolving while we wait on it is the expected completion, not a
  // misprediction: nothing younger was fetched, so no squash is needed.
  always_comb begin
    jxx_mispredict = r_valid_i && (r_icode_i == IJXX) && !r_cnd_i;
    ret_resolve    = r_valid_i && (r_icode_i == IRET);
    ret_mispredict = ret_resolve && (r_valM_i != r_pred_i);
    wait_exit      = (state_q == S_RET_WAIT) && ret_resolve;
    redirect       = jxx_mispredict || (ret_mispredict && !wait_exit);
    predict_en     = (state_q == S_RUN) && f_valid_i && !stall_i && !redirect;
    ras_empty      = (cnt_q == '0);
    ras_full       = (cnt_q == CNT_MAX);
    do_push        = predict_en && (f_icode_i == ICALL);
    do_pop         = predict_en && (f_icode_i == IRET) && !ras_empty;
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: redirects and RET completion return to RUN; prediction may park us.
  always_comb begin
    state_d = state_q;
    if (redirect || wait_exit) begin
      state_d = S_RUN;
    end else if (predict_en) begin
      if ((f_icode_i == IRET) && ras_empty) begin
        state_d = S_RET_WAIT;
      end else if (f_icode_i == IHALT) begin
        state_d = S_HALT;
      end
    end
  end

  // FSM outputs: fetch is only allowed in RUN.
  always_comb begin
    pc_valid_o = (state_q == S_RUN);
    halted_o   = (state_q == S_HALT);
  end

  // Next PC selection: redirect, then RET completion, then fetch prediction.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = jxx_mispredict ? r_valP_i : r_valM_i;
    end else if (wait_exit) begin
      pc_d = r_valM_i;
    end else if (predict_en) begin
      case (f_icode_i)
        ICALL:   pc_d = f_valC_i;
        IJXX:    pc_d = f_valC_i;
        IRET:    pc_d = ras_empty ? pc_q : ras_q[top_q];
        IHALT:   pc_d = pc_q;
        default: pc_d = f_valP_i;
      endcase
    end
  end

  // RAS pointer/count bookkeeping; the circular pointer makes a full push
  // overwrite the oldest entry without any extra shifting.
  always_comb begin
    top_d   = top_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    flush_d = redirect;
    if (redirect) begin
      cnt_d = '0;
    end else if (do_push) begin
      top_d = top_q + 1'b1;
      if (ras_full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (do_pop) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Control registers: PC, flush pulse, RAS pointer/count, sticky overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      ovf_q   <= 1'b0;
      top_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
      ovf_q   <= ovf_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAS storage: entries are only meaningful below the count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (do_push && !redirect) begin
      ras_q[top_d] <= f_valP_i;
    end
  end

  assign pc_o      = pc_q;
  assign flush_o   = flush_q;
  assign ras_ovf_o = ovf_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
// tb/tb_pc_predict_unit.sv - directed self-checking bench for pc_predict_unit
module tb_pc_predict_unit;

  localparam int ADDR_W = 64;

  logic              clk;
  logic              rst;
  logic              stall;
  logic              f_valid;
  logic [3:0]        f_icode;
  logic [ADDR_W-1:0] f_valC;
  logic [ADDR_W-1:0] f_valP;
  logic              r_valid;
  logic [3:0]        r_icode;
  logic              r_cnd;
  logic [ADDR_W-1:0] r_valP;
  logic [ADDR_W-1:0] r_valM;
  logic [ADDR_W-1:0] r_pred;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              flush;
  logic              halted;
  logic              ras_ovf;

  int passes = 0;
  int total  = 0;

  pc_predict_unit #(.ADDR_W(ADDR_W), .RAS_DEPTH(8), .RESET_PC('0)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .stall_i    (stall),
    .f_valid_i  (f_valid),
    .f_icode_i  (f_icode),
    .f_valC_i   (f_valC),
    .f_valP_i   (f_valP),
    .r_valid_i  (r_valid),
    .r_icode_i  (r_icode),
    .r_cnd_i    (r_cnd),
    .r_valP_i   (r_valP),
    .r_valM_i   (r_valM),
    .r_pred_i   (r_pred),
    .pc_o       (pc),
    .pc_valid_o (pc_valid),
    .flush_o    (flush),
    .halted_o   (halted),
    .ras_ovf_o  (ras_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    stall   = 1'b0;
    f_valid = 1'b0;
    f_icode = 4'h1;
    f_valC  = '0;
    f_valP  = '0;
    r_valid = 1'b0;
    r_icode = 4'h1;
    r_cnd   = 1'b0;
    r_valP  = '0;
    r_valM  = '0;
    r_pred  = '0;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp);
    f_valid = 1'b1;
    f_icode = ic;
    f_valC  = vc;
    f_valP  = vp;
  endtask

  task automatic resolve(input logic [3:0] ic, input logic cnd, input logic [63:0] vp,
                         input logic [63:0] vm, input logic [63:0] pr);
    r_valid = 1'b1;
    r_icode = ic;
    r_cnd   = cnd;
    r_valP  = vp;
    r_valM  = vm;
    r_pred  = pr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #3;
    chk("reset_pc", pc, 64'h0);
    chk("reset_valid", pc_valid, 1);
    chk("reset_flush", flush, 0);
    chk("reset_halted", halted, 0);
    chk("reset_ovf", ras_ovf, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // plain instruction: fall through
    fetch(4'h6, 64'h0, 64'h0A);
    tick();
    chk("opq_pc", pc, 64'h0A);
    chk("opq_valid", pc_valid, 1);
    chk("opq_flush", flush, 0);

    // call then return predicted from the RAS
    fetch(4'h8, 64'h100, 64'h13);
    tick();
    chk("call_pc", pc, 64'h100);
    fetch(4'h9, 64'h0, 64'h101);
    tick();
    chk("ret_pred_pc", pc, 64'h13);
    resolve(4'h9, 1'b0, 64'h0, 64'h13, 64'h13);
    tick();
    chk("ret_ok_flush", flush, 0);
    chk("ret_ok_pc", pc, 64'h13);

    // RAS now empty: RET parks in RET_WAIT
    fetch(4'h9, 64'h0, 64'h14);
    tick();
    chk("retwait_valid", pc_valid, 0);
    chk("retwait_pc", pc, 64'h13);
    fetch(4'h6, 64'h0, 64'hEE);
    tick();
    chk("retwait_ignore_fetch", pc, 64'h13);
    resolve(4'h9, 1'b0, 64'h0, 64'h77, 64'h0);
    tick();
    chk("retwait_exit_pc", pc, 64'h77);
    chk("retwait_exit_valid", pc_valid, 1);
    chk("retwait_exit_flush", flush, 0);

    // jump predicted taken, then mispredict redirect under stall clears RAS
    fetch(4'h8, 64'h200, 64'h44);
    tick();
    chk("call2_pc", pc, 64'h200);
    fetch(4'h7, 64'h40, 64'h2B);
    tick();
    chk("jxx_pc", pc, 64'h40);
    stall = 1'b1;
    fetch(4'h9, 64'h0, 64'h0);
    resolve(4'h7, 1'b0, 64'h2B, 64'h0, 64'h0);
    tick();
    chk("jxx_redirect_pc", pc, 64'h2B);
    chk("jxx_redirect_flush", flush, 1);
    tick();
    chk("flush_one_cycle", flush, 0);
    chk("flush_pc_hold", pc, 64'h2B);
    fetch(4'h9, 64'h0, 64'h2C);
    tick();
    chk("ras_cleared_wait", pc_valid, 0);
    chk("ras_cleared_pc", pc, 64'h2B);
    resolve(4'h9, 1'b0, 64'h0, 64'h30, 64'h30);
    tick();
    chk("exit2_pc", pc, 64'h30);
    chk("exit2_flush", flush, 0);

    // stall holds the PC
    stall = 1'b1;
    fetch(4'h6, 64'h0, 64'h99);
    tick();
    chk("stall_hold", pc, 64'h30);

    // nine calls into an eight-entry RAS
    for (int i = 1; i <= 9; i++) begin
      fetch(4'h8, 64'h1000 + 64'(i), 64'(i));
      tick();
      chk("call_seq_pc", pc, 64'h1000 + 64'(i));
      if (i == 8) chk("ovf_not_yet", ras_ovf, 0);
    end
    chk("ovf_set", ras_ovf, 1);
    for (int i = 9; i >= 2; i--) begin
      fetch(4'h9, 64'h0, 64'h0);
      tick();
      chk("ret_seq_pc", pc, 64'(i));
    end
    fetch(4'h9, 64'h0, 64'h0);
    tick();
    chk("ret9_wait", pc_valid, 0);
    chk("ret9_pc", pc, 64'h2);
    resolve(4'h9, 1'b0, 64'h0, 64'h60, 64'h60);
    tick();
    chk("exit3_pc", pc, 64'h60);

    // RET misprediction redirect in RUN; overflow stays sticky
    resolve(4'h9, 1'b0, 64'h0, 64'h88, 64'h60);
    tick();
    chk("ret_mis_pc", pc, 64'h88);
    chk("ret_mis_flush", flush, 1);
    chk("ovf_sticky", ras_ovf, 1);

    // halt, then wrong-path halt recovered by a redirect
    fetch(4'h0, 64'h0, 64'h89);
    tick();
    chk("halt_halted", halted, 1);
    chk("halt_valid", pc_valid, 0);
    chk("halt_pc", pc, 64'h88);
    fetch(4'h6, 64'h0, 64'h90);
    tick();
    chk("halt_hold_pc", pc, 64'h88);
    resolve(4'h7, 1'b0, 64'h50, 64'h0, 64'h0);
    tick();
    chk("unhalt_halted", halted, 0);
    chk("unhalt_pc", pc, 64'h50);
    chk("unhalt_flush", flush, 1);

    // asynchronous reset in the middle of a stalled cycle
    stall = 1'b1;
    fetch(4'h8, 64'h300, 64'h51);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_pc", pc, 64'h0);
    chk("async_rst_ovf", ras_ovf, 0);
    chk("async_rst_flush", flush, 0);
    chk("async_rst_valid", pc_valid, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
